// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a fixed-latency line memory between I-cache and D-cache.
// Define ARB_FIXED_PRIO_EN to give the D port strict priority on ties instead.
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [63:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_done,
  output logic [63:0]       d_rdata,
  output logic              m_readM,
  output logic              m_writeM,
  output logic [ADDR_W-1:0] m_address,
  output logic [63:0]       m_wdata,
  output logic              m_wdata_oe,
  input  logic [63:0]       m_rdata,
  output logic              err_req_overrun
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MEM_LATENCY);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              i_pend_q, i_pend_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic              d_pend_q, d_pend_d;
  logic              d_we_q, d_we_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [63:0]       d_wdata_q, d_wdata_d;
  logic [63:0]       i_rdata_q, i_rdata_d;
  logic [63:0]       d_rdata_q, d_rdata_d;
  logic              m_readM_q, m_readM_d;
  logic              m_writeM_q, m_writeM_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [63:0]       m_wdata_q, m_wdata_d;
  logic              m_oe_q, m_oe_d;
  logic              err_q, err_d;
`ifndef ARB_FIXED_PRIO_EN
  logic              last_gnt_q, last_gnt_d;
`endif

  logic              i_clr, d_clr;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;

  assign i_clr = (state_q == ST_RESP) && (gnt_q == GNT_I);
  assign d_clr = (state_q == ST_RESP) && (gnt_q == GNT_D);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    i_pend_d    = i_pend_q;
    i_addr_d    = i_addr_q;
    d_pend_d    = d_pend_q;
    d_we_d      = d_we_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    m_readM_d   = 1'b0;
    m_writeM_d  = 1'b0;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_oe_d      = m_oe_q;
    err_d       = err_q;
`ifndef ARB_FIXED_PRIO_EN
    last_gnt_d  = last_gnt_q;
`endif
    pick        = GNT_I;
    sel_we      = 1'b0;
    sel_addr    = i_addr_q;

    // A new request in its own port's RESP cycle wins over the completion clear.
    if (i_clr) i_pend_d = 1'b0;
    if (i_req) begin
      if (!i_pend_q || i_clr) begin
        i_pend_d = 1'b1;
        i_addr_d = i_addr;
      end else begin
        err_d = 1'b1;
      end
    end

    if (d_clr) d_pend_d = 1'b0;
    if (d_req) begin
      if (!d_pend_q || d_clr) begin
        d_pend_d  = 1'b1;
        d_we_d    = d_we;
        d_addr_d  = d_addr;
        d_wdata_d = d_wdata;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_pend_q || d_pend_q) begin
`ifdef ARB_FIXED_PRIO_EN
          pick = d_pend_q;
`else
          pick = d_pend_q && (!i_pend_q || (last_gnt_q == GNT_I));
          last_gnt_d = pick;
`endif
          sel_we      = pick && d_we_q;
          sel_addr    = pick ? d_addr_q : i_addr_q;
          gnt_d       = pick;
          m_address_d = sel_addr & LINE_MASK;
          m_readM_d   = !sel_we;
          m_writeM_d  = sel_we;
          m_oe_d      = sel_we;
          if (sel_we) m_wdata_d = d_wdata_q;
          cnt_d       = '0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          m_oe_d  = 1'b0;
          state_d = ST_RESP;
          if (gnt_q == GNT_I) begin
            i_rdata_d = m_rdata;
          end else if (!d_we_q) begin
            d_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gnt_q       <= GNT_I;
      i_pend_q    <= 1'b0;
      i_addr_q    <= '0;
      d_pend_q    <= 1'b0;
      d_we_q      <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      m_readM_q   <= 1'b0;
      m_writeM_q  <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_oe_q      <= 1'b0;
      err_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_q  <= GNT_D;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      i_pend_q    <= i_pend_d;
      i_addr_q    <= i_addr_d;
      d_pend_q    <= d_pend_d;
      d_we_q      <= d_we_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      m_readM_q   <= m_readM_d;
      m_writeM_q  <= m_writeM_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_oe_q      <= m_oe_d;
      err_q       <= err_d;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_q  <= last_gnt_d;
`endif
    end
  end

  assign i_done          = i_clr;
  assign d_done          = d_clr;
  assign i_rdata         = i_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign m_readM         = m_readM_q;
  assign m_writeM        = m_writeM_q;
  assign m_address       = m_address_q;
  assign m_wdata         = m_wdata_q;
  assign m_wdata_oe      = m_oe_q;
  assign err_req_overrun = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts issue/done
// cycles from request times, a monitor pops and compares what the DUT presents.
module tb_mem_port_arbiter;
  localparam int LAT = 4;
  localparam int AW  = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [63:0]   d_wdata, m_rdata;
  logic          i_done, d_done, m_readM, m_writeM, m_wdata_oe, err_req_overrun;
  logic [63:0]   i_rdata, d_rdata, m_wdata;
  logic [AW-1:0] m_address;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
    .m_wdata(m_wdata), .m_wdata_oe(m_wdata_oe), .m_rdata(m_rdata),
    .err_req_overrun(err_req_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          port;     // 0 = I, 1 = D
    bit          we;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          ready;    // first cycle the request may be granted
    int          issue;
    int          done;
    bit          granted;
  } txn_t;

  logic [63:0] mem     [64];
  logic [63:0] ref_mem [64];

  function automatic int lidx(input logic [15:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [63:0] init_line(input int idx);
    return 64'h0123_4567_89ab_cdef ^ (64'(idx) * 64'h9e37_79b9_7f4a_7c15);
  endfunction

  txn_t        iq[$], dq[$], iss_q[$], done_q[$];
  txn_t        act;
  bit          act_valid = 0;
  int          free_cyc  = 0;
  bit          last_d    = 1;
  bit          model_err = 0;
  bit          chk_en    = 0;
  logic [63:0] exp_i_rdata = '0;
  logic [63:0] exp_d_rdata = '0;

  // Monitor first, then advance the reference model for this cycle.
  initial begin
    txn_t t;
    bit ie, de, pick_d;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (iss_q.size() > 0 && iss_q[0].issue == cyc) begin
          t = iss_q.pop_front();
          chk("m_readM_issue", 64'(m_readM), 64'(!t.we));
          chk("m_writeM_issue", 64'(m_writeM), 64'(t.we));
          act = t;
          act_valid = 1;
        end else begin
          chk("strobe_quiet", 64'({m_readM, m_writeM}), 64'd0);
        end
        if (act_valid && cyc <= act.issue + LAT) begin
          chk("m_address", 64'(m_address), 64'(act.addr & 16'hFFFC));
          chk("m_wdata_oe", 64'(m_wdata_oe), 64'(act.we));
          if (act.we) chk("m_wdata", m_wdata, act.wdata);
        end else begin
          act_valid = 0;
          chk("oe_quiet", 64'(m_wdata_oe), 64'd0);
        end
        if (done_q.size() > 0 && done_q[0].done == cyc) begin
          t = done_q.pop_front();
          chk("done_pulse", 64'({i_done, d_done}), t.port ? 64'd1 : 64'd2);
          if (!t.port) exp_i_rdata = t.rdata;
          else if (!t.we) exp_d_rdata = t.rdata;
        end else begin
          chk("done_quiet", 64'({i_done, d_done}), 64'd0);
        end
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        chk("err_req_overrun", 64'(err_req_overrun), 64'(model_err));
      end

      if (!reset_n) begin
        iq.delete(); dq.delete(); iss_q.delete(); done_q.delete();
        act_valid = 0; last_d = 1; model_err = 0;
        exp_i_rdata = '0; exp_d_rdata = '0;
        free_cyc = cyc + 1;
        chk_en = 1;
      end else begin
        if (i_req) begin
          if (iq.size() == 0 || (iq[0].granted && iq[0].done == cyc)) begin
            t = '{port: 0, we: 0, addr: i_addr, wdata: '0, rdata: '0,
                  ready: cyc + 1, issue: 0, done: 0, granted: 0};
            iq.push_back(t);
          end else model_err = 1;
        end
        if (d_req) begin
          if (dq.size() == 0 || (dq[0].granted && dq[0].done == cyc)) begin
            t = '{port: 1, we: d_we, addr: d_addr, wdata: d_wdata, rdata: '0,
                  ready: cyc + 1, issue: 0, done: 0, granted: 0};
            dq.push_back(t);
          end else model_err = 1;
        end
        if (iq.size() > 0 && iq[0].granted && iq[0].done == cyc) void'(iq.pop_front());
        if (dq.size() > 0 && dq[0].granted && dq[0].done == cyc) begin
          t = dq.pop_front();
          if (t.we) ref_mem[lidx(t.addr)] = t.wdata;
        end
        if (cyc >= free_cyc) begin
          ie = iq.size() > 0 && iq[0].ready <= cyc;
          de = dq.size() > 0 && dq[0].ready <= cyc;
          if (ie || de) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_d = de;
`else
            pick_d = de && (!ie || !last_d);
`endif
            last_d = pick_d;
            if (pick_d) t = dq.pop_front(); else t = iq.pop_front();
            t.granted = 1;
            t.issue   = cyc + 1;
            t.done    = cyc + 2 + LAT;
            t.rdata   = ref_mem[lidx(t.addr)];
            if (pick_d) dq.push_front(t); else iq.push_front(t);
            iss_q.push_back(t);
            done_q.push_back(t);
            free_cyc = cyc + 3 + LAT;
          end
        end
      end
    end
  end

  // Line memory: read data valid only LAT cycles after the strobe, garbage otherwise.
  initial begin
    bit rd_act = 0, wr_act = 0;
    int rd_k = 0, wr_k = 0, rd_idx = 0, wr_idx = 0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_readM) begin
        rd_act = 1; rd_k = 0; rd_idx = lidx(m_address);
      end else if (rd_act) rd_k++;
      if (rd_act && rd_k == LAT) begin
        m_rdata = mem[rd_idx];
        rd_act  = 0;
      end else begin
        m_rdata = {$urandom, $urandom};
      end
      if (m_writeM) begin
        wr_act = 1; wr_k = 0; wr_idx = lidx(m_address);
      end else if (wr_act) begin
        if (!m_wdata_oe) wr_act = 0;
        else wr_k++;
      end
      if (wr_act && wr_k == LAT) begin
        mem[wr_idx] = m_wdata;
        wr_act = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'($urandom);
    i_addr  = 16'($urandom);
    d_addr  = 16'($urandom);
    d_wdata = {$urandom, $urandom};
  endtask

  task automatic req_i(input logic [15:0] a);
    i_req = 1'b1; i_addr = a;
  endtask

  task automatic req_d(input logic we, input logic [15:0] a, input logic [63:0] wd);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_address"}, 64'(m_address), 64'd0);
    chk({tag, "_m_wdata"}, m_wdata, 64'd0);
    chk({tag, "_strobes_oe"}, 64'({m_readM, m_writeM, m_wdata_oe}), 64'd0);
    chk({tag, "_dones"}, 64'({i_done, d_done}), 64'd0);
    chk({tag, "_i_rdata"}, i_rdata, 64'd0);
    chk({tag, "_d_rdata"}, d_rdata, 64'd0);
    chk({tag, "_err"}, 64'(err_req_overrun), 64'd0);
  endtask

  function automatic logic [15:0] rnd_i_addr();
    return 16'($urandom) & 16'hFFBF;
  endfunction

  function automatic logic [15:0] rnd_d_addr();
    return 16'($urandom) | 16'h0040;
  endfunction

  initial begin
    reset_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 64; k++) begin
      mem[k]     = init_line(k);
      ref_mem[k] = init_line(k);
    end
    mem[9]     = 64'hdef0_9abc_5678_1234;
    ref_mem[9] = 64'hdef0_9abc_5678_1234;

    repeat (3) tick();
    reset_n = 1'b1;
    check_reset_outputs("reset");

    req_i(16'h0025);
    tick();
    repeat (10) tick();
    chk("i_line_0x24", i_rdata, 64'hdef0_9abc_5678_1234);

    req_d(1'b1, 16'h0040, 64'haaaa_bbbb_cccc_dddd);
    tick();
    repeat (10) tick();
    req_d(1'b0, 16'h0040, 64'h0);
    tick();
    repeat (10) tick();
    chk("d_readback_0x40", d_rdata, 64'haaaa_bbbb_cccc_dddd);

    req_i(rnd_i_addr());
    req_d(1'b0, rnd_d_addr(), 64'h0);
    tick();
    repeat (16) tick();

    req_i(rnd_i_addr());
    repeat (7) tick();
    req_i(rnd_i_addr());
    req_d(1'b1, 16'h0050, {$urandom, $urandom});
    tick();
    repeat (16) tick();

    req_d(1'b0, 16'h0040, 64'h0);
    repeat (7) tick();
    req_d(1'b1, 16'h0044, {$urandom, $urandom});
    tick();
    repeat (12) tick();
    req_d(1'b0, 16'h0044, 64'h0);
    tick();
    repeat (10) tick();

    req_i(rnd_i_addr());
    tick();
    req_i(rnd_i_addr());
    tick();
    req_i(rnd_i_addr());
    tick();
    repeat (12) tick();
    chk("err_sticky", 64'(err_req_overrun), 64'd1);

    req_d(1'b1, 16'h0048, {$urandom, $urandom});
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_reset_outputs("midreset");
    req_d(1'b0, 16'h0048, 64'h0);
    tick();
    repeat (10) tick();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) req_i(rnd_i_addr());
      if ($urandom_range(0, 5) == 0) req_d(1'($urandom), rnd_d_addr(), {$urandom, $urandom});
      tick();
    end
    repeat (20) tick();
    chk("issue_queue_drained", 64'(iss_q.size()), 64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates 4-word (64-bit) line transactions from the I-cache and D-cache onto a single-ported line memory with a fixed multi-cycle latency. Requests are captured into per-port pending buffers, and the two ports are served by round-robin. Each granted transaction is sequenced with exact cycle counting, and data or completion is returned to the requester. The block sits between the cache controllers and the memory.

## Interface
- MEM_LATENCY, 4, cycles from issue cycle (cnt=0) to the cycle memory read data is valid; also the last cycle write data must be held
- ADDR_W, 16, word-address width
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- i_req  in  1  one-cycle pulse: I-cache line read request
- i_addr  in  ADDR_W  word address, sampled with i_req
- i_done  out  1  one-cycle pulse: I line returned
- i_rdata  out  64  line data, valid in i_done cycle and held until next I completion
- d_req  in  1  one-cycle pulse: D-cache line request
- d_we  in  1  1 = line write, 0 = line read; sampled with d_req
- d_addr  in  ADDR_W  word address, sampled with d_req
- d_wdata  in  64  write line, sampled with d_req
- d_done  out  1  one-cycle pulse: D transaction complete
- d_rdata  out  64  read line, valid in d_done cycle for reads and held until next D read
- m_readM  out  1  memory read strobe, high only in issue cycle
- m_writeM  out  1  memory write strobe, high only in issue cycle
- m_address  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}, held from issue through cnt=MEM_LATENCY
- m_wdata  out  64  write line to memory bus driver
- m_wdata_oe  out  1  bus drive enable, high for writes from cnt=0 through cnt=MEM_LATENCY
- m_rdata  in  64  memory read line
- err_req_overrun  out  1  sticky; set if a req pulse arrives while that port is already pending

## Operation
- Pending buffers: i_pend with i_addr; d_pend with d_we, d_addr and d_wdata. A req pulse with pend=0 latches the fields and sets pend at that edge. A req pulse with pend=1 is dropped, and err_req_overrun is set.
- FSM states:
  - IDLE: if any pend is set, grant and go to BUSY with cnt=0. Otherwise stay in IDLE.
  - BUSY: cnt increments each cycle. At cnt=MEM_LATENCY, go to RESP. For a read, m_rdata is captured into the granted port's rdata register at that edge.
  - RESP: pulse the granted port's done, clear its pend, go to IDLE.
- Arbitration applies only in IDLE. With a single pend, that port wins. With both pending, the port not granted last wins (last_grant register).
- Issue cycle (BUSY, cnt=0):
  - m_address is loaded on the grant edge.
  - m_readM is 1 for an I transaction or a D read.
  - m_writeM is 1 for a D write.
  - m_wdata is driven from d_wdata.
- Counter width is clog2(MEM_LATENCY+1). It never wraps past MEM_LATENCY.
- Simultaneous events: a req pulse arriving in its own port's RESP cycle is accepted, because set dominates clear (pend stays 1 and the new fields are latched). The other port's req can be latched in any state.
- Reset mid-transaction: on the next edge, all state clears, the strobes and m_wdata_oe drop, and the in-flight request is discarded with no done.

## Timing
- Reset values:
  - i_done, d_done, m_readM, m_writeM, m_wdata_oe, err_req_overrun = 0
  - m_address, m_wdata, i_rdata, d_rdata = 0
  - FSM = IDLE, cnt = 0, pends = 0
  - last_grant = D, so I wins the first tie
- Single request, idle block: req in cycle t, pend visible t+1, issue (strobe) t+2, data captured at end of t+2+MEM_LATENCY, done in t+3+MEM_LATENCY. This is t+7 for the default.
- Back-to-back transactions: issue-to-issue spacing is MEM_LATENCY+3 cycles. The memory returns to its idle state before the next strobe.
- Strobes are exactly one cycle. m_address and m_wdata are stable from issue through cnt=MEM_LATENCY.

## Configuration
- ARB_FIXED_PRIO_EN defined: when both ports are pending, D always wins, and last_grant is unused.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as specified above.

## Test plan
- I read alone: i_req with i_addr=0x0025 at t; memory holds 0x1234/0x5678/0x9abc/0xdef0 at 0x24–0x27 -> m_readM=1, m_address=0x0024 at t+2; i_done at t+7; i_rdata=0xdef09abc56781234.
- D write then D read: write 0xaaaa_bbbb_cccc_dddd to 0x40 -> m_writeM one cycle, m_wdata_oe high 5 cycles, d_done at t+7. Read of 0x40 -> d_rdata equals the written line.
- Simultaneous i_req and d_req after reset -> I issued first, D issued 7 cycles later. A repeat tie then grants D first (round-robin). With ARB_FIXED_PRIO_EN, D is issued first both times.
- d_req asserted in the RESP cycle of a D read -> the new request is latched, d_done pulses once for the first request, and the second request issues 2 cycles later.
- i_req pulsed twice while pending -> err_req_overrun=1 and stays set. Only one I transaction is issued.
- reset_n low at cnt=2 of a write -> next edge: m_wdata_oe=0, FSM IDLE, no d_done. After reset release, a new request completes normally.
